eth_phy_10g_rx_descrambler: RTL and testbench
=============================================

// Module: eth_phy_10g_rx_descrambler
// PURPOSE
//  10GBASE-R receive stage directly downstream of the 66b block aligner. Takes aligned 64b payload + 2b sync header,
//  self-synchronously descrambles payload (G(x)=1+x^39+x^58), flags invalid sync headers and runs the BER monitor
//  (hi_ber). Output feeds the 64b/66b RX decoder.
// PARAMETERS
//  BER_WINDOW  19531  window length in clk cycles (125 us at 156.25 MHz)
//  BER_THRESH  16     invalid headers within one window that set hi_ber; legal range 1..63
// PORTS
//  clk        in   1   block clock, one 66b block per cycle
//  reset      in   1   synchronous, active-low (reset==0 resets on rising clk)
//  data_in    in   64  scrambled payload from aligner, bit 0 = first received
//  hdr_in     in   2   sync header from aligner
//  aligned_in in   1   block lock from aligner; data_in/hdr_in meaningful only while 1
//  data_out   out  64  descrambled payload
//  hdr_out    out  2   sync header, delayed to match data_out
//  data_valid out  1   data_out/hdr_out valid this cycle
//  hdr_err    out  1   hdr_out is 2'b00 or 2'b11 (qualified by data_valid)
//  hi_ber     out  1   high bit-error-rate indication
//  ber_count  out  6   invalid headers counted in current window, saturating at 63
// BEHAVIOUR
//  Reset: data_out=0, hdr_out=0, data_valid=0, hdr_err=0, hi_ber=0, ber_count=0, scrambler state=0, timer=0, FSM=UNLOCKED.
//  Descrambler: state s[57:0] holds last 58 received scrambled bits (s[57] newest). c={data_in,s} (122b).
//   out[i]=c[i+58]^c[i+19]^c[i], i=0..63; next s=data_in[63:6]. State updates every cycle aligned_in=1,
//   regardless of header validity. All outputs registered: latency exactly 1 cycle.
//  FSM: UNLOCKED -> PRIME when aligned_in=1; PRIME -> RUN next cycle if aligned_in still 1;
//   any state -> UNLOCKED on cycle aligned_in=0.
//   UNLOCKED: data_valid=0, timer=0, ber_count=0, hi_ber=0; s held.
//   PRIME: loads s from first locked block; its output is NOT valid (data_valid=0).
//   RUN: data_valid=1 one cycle after each locked input; first valid word = 2nd locked block.
//  hdr_err=1 iff registered header is 00/11 and block is in PRIME or RUN (0 in UNLOCKED).
//  BER monitor (PRIME and RUN): timer counts 0..BER_WINDOW-1 then wraps to 0.
//   Each invalid header: ber_count+1, saturating at 63.
//   ber_count reaching BER_THRESH -> hi_ber=1 next cycle (mid-window, no wait).
//   On wrap cycle: if ber_count (incl. error on that same cycle) < BER_THRESH -> hi_ber=0; else hi_ber stays 1.
//   ber_count then restarts at 0 (or 1 if the next cycle's block is itself invalid). Counter only restarts at wrap.
//  Lock loss mid-operation: next cycle data_valid=0, hdr_err=0, hi_ber=0, ber_count=0, timer=0; re-lock re-enters PRIME.
//  reset has priority over aligned_in and all events.
// TESTING
//  1 reset=0 for 3 cycles with random inputs/aligned_in=1 -> all outputs 0, data_valid stays 0.
//  2 aligned_in rises, data_in=64'h8000_0000_0000_0000 then 64'h0 -> first cycle data_valid=0;
//    second output data_out=64'h0200_0040_0000_0000, data_valid=1.
//  3 random 1000-block payload scrambled by bench model, hdr=2'b01 -> data_out matches original,
//    1-cycle latency, hdr_err=0, hi_ber=0.
//  4 BER_WINDOW=100: inject 16 hdr=2'b11 in one window -> hi_ber=1 the cycle after 16th error, ber_count=16;
//    next window 0 errors -> hi_ber=0 at wrap.
//  5 15 errors in one window, 1 more on first cycle of next -> hi_ber stays 0; 70 errors -> ber_count saturates at 63.
//  6 drop aligned_in for 1 cycle while hi_ber=1 -> hi_ber=0, data_valid=0 next cycle; re-lock -> PRIME,
//    valid output resumes after one block.

Source files
------------

// File: rtl/eth_phy_10g_rx_descrambler.sv
// rtl/eth_phy_10g_rx_descrambler.sv - 10GBASE-R RX self-synchronous descrambler with sync-header check and BER monitor
module eth_phy_10g_rx_descrambler #(
  parameter int BER_WINDOW = 19531,
  parameter int BER_THRESH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] data_in,
  input  logic [1:0]  hdr_in,
  input  logic        aligned_in,
  output logic [63:0] data_out,
  output logic [1:0]  hdr_out,
  output logic        data_valid,
  output logic        hdr_err,
  output logic        hi_ber,
  output logic [5:0]  ber_count
);

  localparam int TW = (BER_WINDOW > 1) ? $clog2(BER_WINDOW) : 1;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    PRIME    = 2'd1,
    RUN      = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [57:0]   scr_q, scr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    ber_count_q, ber_count_d;
  logic          hi_ber_q, hi_ber_d;
  logic [63:0]   data_out_q, data_out_d;
  logic [1:0]    hdr_out_q, hdr_out_d;
  logic          data_valid_q, data_valid_d;
  logic          hdr_err_q, hdr_err_d;

  logic [121:0]  c;
  logic [63:0]   descr;
  logic          hdr_bad;
  logic          wrap;
  logic [5:0]    ber_count_inc;
  logic          over_thresh;

  // Sync headers 01/10 are legal; 00/11 are errors.
  assign hdr_bad       = (hdr_in == 2'b00) || (hdr_in == 2'b11);
  // Last cycle of the BER window; the window restarts at 0 next cycle.
  assign wrap          = (timer_q == TW'(BER_WINDOW - 1));
  // Error count including this cycle's block, saturating at 63.
  assign ber_count_inc = (hdr_bad && (ber_count_q != 6'd63)) ? ber_count_q + 6'd1 : ber_count_q;
  assign over_thresh   = (ber_count_inc >= 6'(BER_THRESH));

  // Descramble x^58 + x^39 + 1 over the 58 history bits plus the new payload.
  always_comb begin
    c = {data_in, scr_q};
    descr = '0;
    for (int i = 0; i < 64; i++) begin
      descr[i] = c[i + 58] ^ c[i + 19] ^ c[i];
    end
  end

  // Lock FSM: the first locked block only primes the descrambler history.
  always_comb begin
    state_d = state_q;
    if (!aligned_in) begin
      state_d = UNLOCKED;
    end else begin
      case (state_q)
        UNLOCKED: state_d = PRIME;
        PRIME:    state_d = RUN;
        RUN:      state_d = RUN;
        default:  state_d = UNLOCKED;
      endcase
    end
  end

  // Datapath and BER monitor next values; everything clears while unlocked.
  always_comb begin
    scr_d        = scr_q;
    data_out_d   = data_out_q;
    hdr_out_d    = hdr_out_q;
    data_valid_d = 1'b0;
    hdr_err_d    = 1'b0;
    timer_d      = '0;
    ber_count_d  = '0;
    hi_ber_d     = 1'b0;
    if (aligned_in) begin
      scr_d        = data_in[63:6];
      data_out_d   = descr;
      hdr_out_d    = hdr_in;
      data_valid_d = (state_q != UNLOCKED);
      hdr_err_d    = hdr_bad;
      if (wrap) begin
        // Window closes: hi_ber follows this window's total, counting restarts.
        timer_d     = '0;
        ber_count_d = '0;
        hi_ber_d    = over_thresh;
      end else begin
        timer_d     = timer_q + TW'(1);
        ber_count_d = ber_count_inc;
        hi_ber_d    = hi_ber_q | over_thresh;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= UNLOCKED;
      scr_q        <= '0;
      timer_q      <= '0;
      ber_count_q  <= '0;
      hi_ber_q     <= 1'b0;
      data_out_q   <= '0;
      hdr_out_q    <= '0;
      data_valid_q <= 1'b0;
      hdr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scr_q        <= scr_d;
      timer_q      <= timer_d;
      ber_count_q  <= ber_count_d;
      hi_ber_q     <= hi_ber_d;
      data_out_q   <= data_out_d;
      hdr_out_q    <= hdr_out_d;
      data_valid_q <= data_valid_d;
      hdr_err_q    <= hdr_err_d;
    end
  end

  assign data_out   = data_out_q;
  assign hdr_out    = hdr_out_q;
  assign data_valid = data_valid_q;
  assign hdr_err    = hdr_err_q;
  assign hi_ber     = hi_ber_q;
  assign ber_count  = ber_count_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_descrambler.sv
// tb/tb_eth_phy_10g_rx_descrambler.sv - randomized model-checked bench for the 10GBASE-R RX descrambler
module tb_eth_phy_10g_rx_descrambler;

  localparam int W = 100;
  localparam int T = 16;

  logic        clk;
  logic        reset;
  logic [63:0] data_in;
  logic [1:0]  hdr_in;
  logic        aligned_in;
  logic [63:0] data_out;
  logic [1:0]  hdr_out;
  logic        data_valid;
  logic        hdr_err;
  logic        hi_ber;
  logic [5:0]  ber_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: serial bit stream received since lock, window bookkeeping.
  bit          hist[$];
  int          m_nlock = 0;
  int          m_errs  = 0;
  logic        e_valid, e_err, e_hi;
  int          e_cnt;
  logic [63:0] e_data;
  logic [1:0]  e_hdr;

  eth_phy_10g_rx_descrambler #(
    .BER_WINDOW(W),
    .BER_THRESH(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .hdr_in     (hdr_in),
    .aligned_in (aligned_in),
    .data_out   (data_out),
    .hdr_out    (hdr_out),
    .data_valid (data_valid),
    .hdr_err    (hdr_err),
    .hi_ber     (hi_ber),
    .ber_count  (ber_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  function automatic bit bit_at(input int m, input logic [63:0] w, input int base);
    if (m >= base) return w[m - base];
    return hist[m];
  endfunction

  // Serial scrambler: s[n] = d[n] ^ s[n-39] ^ s[n-58], continuing the received stream.
  function automatic logic [63:0] scramble(input logic [63:0] pay);
    logic [63:0] w;
    int base;
    base = hist.size();
    w = '0;
    for (int i = 0; i < 64; i++) begin
      w[i] = pay[i] ^ bit_at(base + i - 39, w, base) ^ bit_at(base + i - 58, w, base);
    end
    return w;
  endfunction

  // Apply one block, advance the model, clock once and compare every output.
  task automatic cycle(input logic rst, input logic al, input logic [63:0] d, input logic [1:0] h);
    logic bad;
    int   base;
    reset      = rst;
    aligned_in = al;
    data_in    = d;
    hdr_in     = h;
    bad = (h == 2'b00) || (h == 2'b11);
    if (!rst) begin
      e_valid = 0; e_err = 0; e_hi = 0; e_cnt = 0; e_data = '0; e_hdr = '0;
      m_nlock = 0; m_errs = 0; hist.delete();
    end else if (!al) begin
      e_valid = 0; e_err = 0; e_hi = 0; e_cnt = 0;
      m_nlock = 0; m_errs = 0; hist.delete();
    end else begin
      base = hist.size();
      for (int i = 0; i < 64; i++) hist.push_back(d[i]);
      e_valid = (m_nlock > 0);
      if (e_valid) begin
        for (int i = 0; i < 64; i++) begin
          e_data[i] = hist[base + i] ^ hist[base + i - 39] ^ hist[base + i - 58];
        end
      end
      e_hdr = h;
      e_err = bad;
      if (bad) m_errs++;
      if ((m_nlock % W) == W - 1) begin
        e_hi   = (m_errs >= T);
        e_cnt  = 0;
        m_errs = 0;
      end else begin
        if (m_errs >= T) e_hi = 1;
        e_cnt = (m_errs > 63) ? 63 : m_errs;
      end
      m_nlock++;
    end
    @(posedge clk);
    #1;
    check_eq("data_valid", data_valid, e_valid);
    check_eq("hdr_err", hdr_err, e_err);
    check_eq("hi_ber", hi_ber, e_hi);
    check_eq("ber_count", ber_count, 64'(e_cnt));
    if (!rst || e_valid) begin
      check_eq("data_out", data_out, e_data);
      check_eq("hdr_out", hdr_out, e_hdr);
    end
  endtask

  initial begin
    logic [63:0] pay;
    logic [63:0] w;
    reset = 1'b0; aligned_in = 1'b0; data_in = '0; hdr_in = 2'b01;

    // Reset held low with live-looking inputs.
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, rand64(), $urandom_range(0, 3));

    // Single-bit priming block followed by zeros.
    cycle(1'b1, 1'b1, 64'h8000_0000_0000_0000, 2'b01);
    check_eq("t2_prime_invalid", data_valid, 1'b0);
    cycle(1'b1, 1'b1, 64'h0, 2'b01);
    check_eq("t2_valid", data_valid, 1'b1);
    check_eq("t2_data", data_out, 64'h0200_0040_0000_0000);

    // Scrambled random payload must come back unchanged one cycle later.
    cycle(1'b1, 1'b0, rand64(), 2'b01);
    cycle(1'b1, 1'b1, rand64(), 2'b01);
    for (int k = 0; k < 1000; k++) begin
      pay = rand64();
      w = scramble(pay);
      cycle(1'b1, 1'b1, w, 2'b01);
      check_eq("t3_payload", data_out, pay);
    end

    // BER threshold crossing and window-end clear.
    cycle(1'b1, 1'b0, rand64(), 2'b01);
    for (int k = 0; k < 372; k++) begin
      logic err;
      err = (k >= 10 && k <= 25) || (k >= 285 && k <= 370);
      cycle(1'b1, 1'b1, rand64(), err ? bad_hdr() : good_hdr());
      if (k == 24) check_eq("t4_hi_before", hi_ber, 1'b0);
      if (k == 25) begin
        check_eq("t4_hi_set", hi_ber, 1'b1);
        check_eq("t4_cnt16", ber_count, 6'd16);
      end
      if (k == 198) check_eq("t4_hi_held", hi_ber, 1'b1);
      if (k == 199) check_eq("t4_hi_clear", hi_ber, 1'b0);
      if (k == 299) begin
        check_eq("t5_wrap_cnt", ber_count, 6'd0);
        check_eq("t5_wrap_hi", hi_ber, 1'b0);
      end
      if (k == 300) begin
        check_eq("t5_restart_cnt", ber_count, 6'd1);
        check_eq("t5_restart_hi", hi_ber, 1'b0);
      end
      if (k == 370) begin
        check_eq("t5_sat", ber_count, 6'd63);
        check_eq("t5_hi", hi_ber, 1'b1);
      end
    end

    // Lock loss while hi_ber is set, then re-lock.
    cycle(1'b1, 1'b0, rand64(), 2'b11);
    check_eq("t6_hi_drop", hi_ber, 1'b0);
    check_eq("t6_valid_drop", data_valid, 1'b0);
    check_eq("t6_cnt_drop", ber_count, 6'd0);
    cycle(1'b1, 1'b1, rand64(), 2'b01);
    check_eq("t6_prime", data_valid, 1'b0);
    cycle(1'b1, 1'b1, rand64(), 2'b01);
    check_eq("t6_resume", data_valid, 1'b1);

    // Random mix of lock drops, occasional resets and header errors near threshold.
    for (int k = 0; k < 3000; k++) begin
      logic rst_n, al;
      rst_n = ($urandom_range(0, 499) != 0);
      al    = ($urandom_range(0, 149) != 0);
      cycle(rst_n, al, rand64(), ($urandom_range(0, 5) == 0) ? bad_hdr() : good_hdr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
